guarded_counter_scrubber: RTL and testbench
===========================================

# guarded_counter_scrubber

Controller that owns a guarded unsigned counter and shares its increment port between two requesters through a round-robin arbiter. The counter value carries even/odd bit-population guards. A periodic scrub state machine re-derives the guards, detects corruption, and rolls the counter back to the last verified value. It sits between event sources and the guarded counter datapath, and adds arbitration, scheduling and recovery around it.

## Interface
- `width`, 8: counter width in bits; must be even and ≥ 2.
- `guard_bits`, 4: width of each guard count; popcounts are taken modulo 2^guard_bits.
- `scrub_period`, 16: number of COUNT-state cycles between checks; must be ≥ 2.
- `err_bits`, 4: width of the saturating error counter.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rstn`, input, 1: synchronous, active-high reset.
- `req`, input, 2: increment requests; bit k belongs to requester k.
- `gnt`, output, 2: one-hot or zero grant; combinational from `req`, state and priority pointer.
- `inject_en`, input, 1: fault-injection strobe, for verification.
- `inject_mask`, input, width: bits XORed into `out` when `inject_en` is high.
- `err_clr`, input, 1: clears sticky `err`.
- `out`, output, width: counter value (registered).
- `even_bit`, output, guard_bits: stored popcount of `out` bits 0,2,4…
- `odd_bit`, output, guard_bits: stored popcount of `out` bits 1,3,5…
- `err`, output, 1: sticky mismatch flag.
- `err_cnt`, output, err_bits: number of mismatches, saturating.
- `busy`, output, 1: high whenever the state is not COUNT.

## Operation
FSM states are COUNT, CHECK and RECOVER. Reset enters COUNT.

**Reset values.** With `rstn`=1 at an edge, the following all become 0: `out`, `even_bit`, `odd_bit`, `err`, `err_cnt`, the shadow register, the scrub timer and `busy`. The priority pointer is set so requester 0 wins first. `gnt`=0 while `rstn`=1. Reset overrides every other input.

**COUNT**
- Grant logic:
  - If exactly one `req` bit is set, grant it.
  - If both are set, grant the requester not granted most recently.
  - The pointer updates only on a grant.
- A grant increments `out` by 1 modulo 2^width; 2^width−1 wraps to 0 with no flag.
- On the same edge, `even_bit`/`odd_bit` load the popcounts of the new value.
- With no grant, `out` and the guards hold.
- The timer increments every COUNT cycle. When it equals `scrub_period`−1, the next state is CHECK and the timer clears.

**CHECK** (1 cycle)
- `gnt`=0 and `out` holds.
- Compare the popcounts of the current `out` against `even_bit`/`odd_bit`.
- Match: the shadow register loads `out`; next state is COUNT.
- Mismatch: `err` is set, `err_cnt` increments (saturating at 2^err_bits−1), and next state is RECOVER.

**RECOVER** (1 cycle)
- `gnt`=0.
- `out` loads the shadow, and the guards load the shadow's popcounts.
- Next state is COUNT.

**Injection**
- At any edge with `inject_en`=1 (not reset, not RECOVER), `out` takes its normal next value XOR `inject_mask`.
- The guards take the un-injected value's popcounts, so the corruption is detectable.
- In RECOVER, the reload wins and the injection is dropped.

**Sticky error**
- `err_clr`=1 clears `err` but not `err_cnt`.
- If `err_clr` coincides with a mismatch, set wins.

Requests are never queued: a requester not granted in a cycle must keep `req` asserted.

## Timing
- `gnt` is valid in the same cycle as `req`. `out` reflects the grant one edge later.
- The guards update on the same edge as `out`, so they are never a cycle stale.
- After reset deasserts, the first CHECK occurs on COUNT cycle `scrub_period`. `busy` is high for that one cycle on a pass, or for 2 cycles on a mismatch (CHECK then RECOVER).
- Mismatch to `err`=1 latency: 1 edge after the CHECK cycle. `out` is restored 1 edge after that.
- Scrub cadence is fixed: exactly `scrub_period` COUNT cycles separate consecutive CHECKs, regardless of request activity.
- Reset in any state, including mid-RECOVER, gives all outputs their reset values after the next edge.

## Test plan
1. **Single requester.** Reset, then `req`=01 for 5 cycles → `gnt`=01 each cycle, `out`=1…5. At `out`=5: `even_bit`=2, `odd_bit`=0. `err`=0.
2. **Round-robin.** Both requesters assert `req`=11 continuously → `gnt` alternates 01,10,01,10 starting with 01. `out` increments every COUNT cycle.
3. **Wrap.** Drive `out` to 255 with `req`=01, then one more grant → `out`=0, guards 0/0, the next CHECK passes, `err`=0.
4. **Scrub cadence.** `req`=11 held from reset → cycle 16 has `busy`=1, `gnt`=00 and `out` held. After 16 more COUNT cycles another CHECK occurs. `err` stays 0.
5. **Fault recovery.** After a passing CHECK with shadow=16, pulse `inject_en` with mask 8'h01 → `out` is off by bit 0. At the next CHECK, `err`=1 and `err_cnt`=1. After RECOVER, `out`=16 and guards=1/0. The following CHECK passes.
6. **Corner cases.**
   - `err_clr` with a simultaneous mismatch → `err` stays 1.
   - Assert `rstn` during RECOVER → next cycle `out`=0, `err`=0, `err_cnt`=0, `busy`=0.
   - 15 forced mismatches followed by another → `err_cnt` stays 15.

Source files
------------

// File: rtl/guarded_counter_scrubber_if.sv
// Request/grant handshake between the two event sources and the guarded counter controller.
interface guarded_counter_scrubber_if;
    logic [1:0] req;
    logic [1:0] gnt;

    modport master (output req, input gnt);
    modport slave  (input req, output gnt);
endinterface

// File: rtl/guarded_counter_scrubber.sv
// Guarded counter with a two-way round-robin increment port and a periodic scrub FSM that
// re-derives the even/odd popcount guards and rolls back to the last verified value on corruption.
module guarded_counter_scrubber #(
    parameter int width        = 8,
    parameter int guard_bits   = 4,
    parameter int scrub_period = 16,
    parameter int err_bits     = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    guarded_counter_scrubber_if.slave        bus,
    input  logic                             inject_en,
    input  logic [width-1:0]                 inject_mask,
    input  logic                             err_clr,
    output logic [width-1:0]                 out,
    output logic [guard_bits-1:0]            even_bit,
    output logic [guard_bits-1:0]            odd_bit,
    output logic                             err,
    output logic [err_bits-1:0]              err_cnt,
    output logic                             busy
);
    localparam int                   timer_w    = $clog2(scrub_period);
    localparam logic [timer_w-1:0]   timer_last = timer_w'(scrub_period - 1);
    localparam logic [err_bits-1:0]  err_max    = '1;

    typedef enum logic [1:0] {ST_COUNT, ST_CHECK, ST_RECOVER} state_t;

    state_t             state;
    logic [width-1:0]   shadow;
    logic [timer_w-1:0] timer;
    logic               last_gnt;   // index of the requester granted most recently

    logic [1:0]         grant;
    logic [width-1:0]   plain_next;
    logic [width-1:0]   inj;
    logic               mismatch;

    // Popcount of every other bit starting at 'first', wrapping modulo 2^guard_bits.
    function automatic logic [guard_bits-1:0] popcount(input logic [width-1:0] v, input int first);
        logic [guard_bits-1:0] c;
        c = '0;
        for (int i = first; i < width; i += 2) begin
            c = c + guard_bits'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        // NOTE: default first so every path assigns grant; a missing branch would infer a latch.
        grant = 2'b00;
        if (!rstn && state == ST_COUNT) begin
            case (bus.req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_gnt ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign bus.gnt    = grant;
    assign plain_next = (grant != 2'b00) ? out + width'(1) : out;
    assign inj        = inject_en ? inject_mask : '0;
    assign mismatch   = (popcount(out, 0) != even_bit) || (popcount(out, 1) != odd_bit);

    always_ff @(posedge clk) begin
        if (rstn) begin
            state    <= ST_COUNT;
            out      <= '0;
            even_bit <= '0;
            odd_bit  <= '0;
            shadow   <= '0;
            timer    <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
            busy     <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            // NOTE: a later non-blocking assignment to err in this block overrides this clear,
            // so a mismatch on the same edge leaves err set.
            if (err_clr) err <= 1'b0;

            case (state)
                ST_COUNT: begin
                    out <= plain_next ^ inj;
                    if (grant != 2'b00) begin
                        even_bit <= popcount(plain_next, 0);
                        odd_bit  <= popcount(plain_next, 1);
                        last_gnt <= grant[1];
                    end
                    if (timer == timer_last) begin
                        timer <= '0;
                        state <= ST_CHECK;
                        busy  <= 1'b1;
                    end else begin
                        timer <= timer + timer_w'(1);
                    end
                end
                ST_CHECK: begin
                    out <= out ^ inj;
                    if (mismatch) begin
                        err   <= 1'b1;
                        state <= ST_RECOVER;
                        if (err_cnt != err_max) err_cnt <= err_cnt + err_bits'(1);
                    end else begin
                        shadow <= out;
                        state  <= ST_COUNT;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    // Rollback reload takes priority over any injection this cycle.
                    out      <= shadow;
                    even_bit <= popcount(shadow, 0);
                    odd_bit  <= popcount(shadow, 1);
                    state    <= ST_COUNT;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_guarded_counter_scrubber.sv
// Directed bench for guarded_counter_scrubber: arbitration, wrap, scrub cadence, fault rollback,
// sticky error handling, reset during RECOVER and error-counter saturation.
module tb_guarded_counter_scrubber;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       inject_en = 1'b0;
    logic [7:0] inject_mask = 8'h00;
    logic       err_clr = 1'b0;
    logic [7:0] out;
    logic [3:0] even_bit;
    logic [3:0] odd_bit;
    logic       err;
    logic [3:0] err_cnt;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    guarded_counter_scrubber_if bus();

    guarded_counter_scrubber #(
        .width(8), .guard_bits(4), .scrub_period(16), .err_bits(4)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .inject_en(inject_en), .inject_mask(inject_mask), .err_clr(err_clr),
        .out(out), .even_bit(even_bit), .odd_bit(odd_bit),
        .err(err), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance one cycle; outputs are observed on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        rstn = 1'b1; bus.req = 2'b00; inject_en = 1'b0; inject_mask = 8'h00; err_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; bus.req = 2'b11; inject_en = 1'b1; inject_mask = 8'hff; err_clr = 1'b0;
        @(negedge clk); #1;
        vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got %b exp 00", bus.gnt); end
        @(posedge clk); @(negedge clk);
        vectors++; if (out !== 8'd0) begin miscompares++; $display("FAIL reset_out got %0d exp 0", out); end
        vectors++; if (even_bit !== 4'd0 || odd_bit !== 4'd0) begin miscompares++; $display("FAIL reset_guards got %0d/%0d exp 0/0", even_bit, odd_bit); end
        vectors++; if (err !== 1'b0 || err_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_err got %b/%0d exp 0/0", err, err_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        inject_en = 1'b0; inject_mask = 8'h00; rstn = 1'b0; cyc = 0; #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL reset_first_gnt got %b exp 01", bus.gnt); end
        bus.req = 2'b00;
    endtask

    task automatic test_single();
        apply_reset();
        bus.req = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            #1;
            vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL single_gnt step %0d got %b exp 01", i, bus.gnt); end
            tick();
            vectors++; if (out !== 8'(i)) begin miscompares++; $display("FAIL single_out step %0d got %0d exp %0d", i, out, i); end
        end
        vectors++; if (even_bit !== 4'd2 || odd_bit !== 4'd0) begin miscompares++; $display("FAIL single_guards got %0d/%0d exp 2/0", even_bit, odd_bit); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL single_err got %b exp 0", err); end
        bus.req = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        apply_reset();
        bus.req = 2'b11;
        exp_gnt = 2'b01;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (bus.gnt !== exp_gnt) begin miscompares++; $display("FAIL rr_gnt step %0d got %b exp %b", i, bus.gnt, exp_gnt); end
            tick();
            vectors++; if (out !== 8'(i + 1)) begin miscompares++; $display("FAIL rr_out step %0d got %0d exp %0d", i, out, i + 1); end
            exp_gnt = (exp_gnt == 2'b01) ? 2'b10 : 2'b01;
        end
        bus.req = 2'b00;
    endtask

    task automatic test_wrap();
        int grants;
        bit bumped;
        apply_reset();
        bus.req = 2'b01;
        grants = 0;
        while (grants < 256) begin
            bumped = (cyc % 17 != 16);
            if (bumped) grants++;
            tick();
            if (bumped && grants == 255) begin
                vectors++; if (out !== 8'd255) begin miscompares++; $display("FAIL wrap_top got %0d exp 255", out); end
            end
        end
        bus.req = 2'b00;
        vectors++; if (out !== 8'd0) begin miscompares++; $display("FAIL wrap_out got %0d exp 0", out); end
        vectors++; if (even_bit !== 4'd0 || odd_bit !== 4'd0) begin miscompares++; $display("FAIL wrap_guards got %0d/%0d exp 0/0", even_bit, odd_bit); end
        while (cyc % 17 != 16) tick();
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wrap_check_busy got %b exp 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0 || err !== 1'b0 || err_cnt !== 4'd0) begin miscompares++; $display("FAIL wrap_check_pass busy/err/cnt got %b/%b/%0d exp 0/0/0", busy, err, err_cnt); end
    endtask

    task automatic test_scrub_cadence();
        logic [1:0] exp_gnt;
        apply_reset();
        bus.req = 2'b11;
        exp_gnt = 2'b01;
        for (int i = 0; i < 16; i++) begin
            #1;
            vectors++; if (bus.gnt !== exp_gnt || busy !== 1'b0) begin miscompares++; $display("FAIL cad_count cycle %0d gnt/busy got %b/%b exp %b/0", i, bus.gnt, busy, exp_gnt); end
            tick();
            exp_gnt = (exp_gnt == 2'b01) ? 2'b10 : 2'b01;
        end
        #1;
        vectors++; if (busy !== 1'b1 || bus.gnt !== 2'b00 || out !== 8'd16) begin miscompares++; $display("FAIL cad_check1 busy/gnt/out got %b/%b/%0d exp 1/00/16", busy, bus.gnt, out); end
        tick(); #1;
        vectors++; if (busy !== 1'b0 || out !== 8'd16 || bus.gnt !== exp_gnt) begin miscompares++; $display("FAIL cad_after1 busy/out/gnt got %b/%0d/%b exp 0/16/%b", busy, out, bus.gnt, exp_gnt); end
        repeat (16) tick();
        #1;
        vectors++; if (busy !== 1'b1 || bus.gnt !== 2'b00 || out !== 8'd32) begin miscompares++; $display("FAIL cad_check2 busy/gnt/out got %b/%b/%0d exp 1/00/32", busy, bus.gnt, out); end
        tick();
        vectors++; if (busy !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL cad_after2 busy/err got %b/%b exp 0/0", busy, err); end
        bus.req = 2'b00;
    endtask

    task automatic test_fault_recovery();
        apply_reset();
        bus.req = 2'b11;
        repeat (16) tick();
        #1;
        vectors++; if (busy !== 1'b1 || out !== 8'd16) begin miscompares++; $display("FAIL fault_first_check busy/out got %b/%0d exp 1/16", busy, out); end
        bus.req = 2'b00;
        tick();
        inject_en = 1'b1; inject_mask = 8'h01;
        tick();
        inject_en = 1'b0;
        vectors++; if (out !== 8'd17 || even_bit !== 4'd1 || odd_bit !== 4'd0) begin miscompares++; $display("FAIL fault_injected out/guards got %0d/%0d/%0d exp 17/1/0", out, even_bit, odd_bit); end
        repeat (15) tick();
        vectors++; if (busy !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL fault_check busy/err got %b/%b exp 1/0", busy, err); end
        tick();
        vectors++; if (err !== 1'b1 || err_cnt !== 4'd1 || busy !== 1'b1 || out !== 8'd17) begin miscompares++; $display("FAIL fault_detect err/cnt/busy/out got %b/%0d/%b/%0d exp 1/1/1/17", err, err_cnt, busy, out); end
        inject_en = 1'b1; inject_mask = 8'h80;
        tick();
        inject_en = 1'b0;
        vectors++; if (out !== 8'd16 || even_bit !== 4'd1 || odd_bit !== 4'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL fault_restore out/guards/busy got %0d/%0d/%0d/%b exp 16/1/0/0", out, even_bit, odd_bit, busy); end
        repeat (16) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fault_recheck busy got %b exp 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0 || err_cnt !== 4'd1 || out !== 8'd16) begin miscompares++; $display("FAIL fault_recheck_pass busy/cnt/out got %b/%0d/%0d exp 0/1/16", busy, err_cnt, out); end
    endtask

    task automatic test_err_clr();
        apply_reset();
        inject_en = 1'b1; inject_mask = 8'h01;
        tick();
        inject_en = 1'b0;
        repeat (15) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (err !== 1'b1 || err_cnt !== 4'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL clr_collide err/cnt/busy got %b/%0d/%b exp 1/1/1", err, err_cnt, busy); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (err !== 1'b0 || err_cnt !== 4'd1 || out !== 8'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL clr_alone err/cnt/out/busy got %b/%0d/%0d/%b exp 0/1/0/0", err, err_cnt, out, busy); end
    endtask

    task automatic test_reset_in_recover();
        apply_reset();
        inject_en = 1'b1; inject_mask = 8'h01;
        tick();
        inject_en = 1'b0;
        repeat (16) tick();
        vectors++; if (busy !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL rst_rec_pre busy/err got %b/%b exp 1/1", busy, err); end
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        vectors++; if (out !== 8'd0 || err !== 1'b0 || err_cnt !== 4'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_rec out/err/cnt/busy got %0d/%b/%0d/%b exp 0/0/0/0", out, err, err_cnt, busy); end
        vectors++; if (even_bit !== 4'd0 || odd_bit !== 4'd0) begin miscompares++; $display("FAIL rst_rec_guards got %0d/%0d exp 0/0", even_bit, odd_bit); end
    endtask

    task automatic test_err_saturation();
        int exp_cnt;
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            inject_en = 1'b1; inject_mask = 8'h01;
            tick();
            inject_en = 1'b0;
            repeat (15) tick();
            tick();
            exp_cnt = (k + 1 > 15) ? 15 : k + 1;
            vectors++; if (err_cnt !== 4'(exp_cnt)) begin miscompares++; $display("FAIL sat_cnt round %0d got %0d exp %0d", k, err_cnt, exp_cnt); end
            tick();
        end
        vectors++; if (err !== 1'b1 || out !== 8'd0) begin miscompares++; $display("FAIL sat_final err/out got %b/%0d exp 1/0", err, out); end
    endtask

    initial begin
        bus.req = 2'b00;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_scrub_cadence();
        test_fault_recovery();
        test_err_clr();
        test_reset_in_recover();
        test_err_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
